// File: rtl/guess_round_if.sv
// Bundles the key/switch/scorer inputs and the display/status outputs of
// one bulls-and-cows turn controller. The controller uses the slave modport;
// the upstream key logic and downstream display use the master side.
interface guess_round_if #(
    parameter int DIGITS = 4
);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // Upstream keys, switch encoder and combinational scorer
    logic                  start_pulse;
    logic                  confirm_pulse;
    logic                  back_pulse;
    logic                  digit_valid;
    logic [3:0]            digit_in;
    logic                  blink_tick;
    logic [2:0]            count_a_in;
    logic [2:0]            count_b_in;

    // Guess, result and game status towards scorer and LED/HEX logic
    logic [4*DIGITS-1:0]   guess_flat;
    logic [IDX_W-1:0]      guess_idx;
    logic                  dup_err;
    logic [2:0]            result_a;
    logic [2:0]            result_b;
    logic                  result_show;
    logic [2:0]            turn_count;
    logic                  in_entry;
    logic                  win;
    logic                  lose;

    modport master (
        output start_pulse, confirm_pulse, back_pulse, digit_valid, digit_in,
               blink_tick, count_a_in, count_b_in,
        input  guess_flat, guess_idx, dup_err, result_a, result_b,
               result_show, turn_count, in_entry, win, lose
    );

    modport slave (
        input  start_pulse, confirm_pulse, back_pulse, digit_valid, digit_in,
               blink_tick, count_a_in, count_b_in,
        output guess_flat, guess_idx, dup_err, result_a, result_b,
               result_show, turn_count, in_entry, win, lose
    );
endinterface

// File: rtl/guess_round_ctrl.sv
// One player turn of 4-digit bulls-and-cows: digit entry with duplicate
// rejection and backspace, scorer settle wait, timed result display, turn
// accounting and sticky win/lose.
// Optional build macro ALLOW_DUP_DIGITS_EN: when defined, repeated digits are
// accepted and dup_err never pulses.
module guess_round_ctrl #(
    parameter int DIGITS     = 4,
    parameter int MAX_TURNS  = 5,
    parameter int SETTLE_CYC = 2,   // 1..15
    parameter int SHOW_TICKS = 4    // 1..15
) (
    input logic            CLK,
    input logic            RESET,
    guess_round_if.slave   bus
);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTRY,
        S_SETTLE,
        S_SHOW,
        S_WIN,
        S_LOSE
    } state_t;

    state_t              state_q,  state_d;
    logic [4*DIGITS-1:0] guess_q,  guess_d;
    logic [IDX_W-1:0]    idx_q,    idx_d;
    logic                dup_err_q, dup_err_d;
    logic [2:0]          res_a_q,  res_a_d;
    logic [2:0]          res_b_q,  res_b_d;
    logic [2:0]          turn_q,   turn_d;
    logic [3:0]          settle_q, settle_d;
    logic [3:0]          tick_q,   tick_d;
    logic                win_q,    win_d;
    logic                lose_q,   lose_d;
    logic                digit_ok;
    logic                is_dup;

    // State register and all datapath registers
    always_ff @(posedge CLK) begin
        // NOTE: the guess digits are an ordinary register bank, so they take
        // their "empty" value on reset like any other state; they are not RAM.
        if (RESET) begin
            state_q   <= S_IDLE;
            guess_q   <= '1;
            idx_q     <= '0;
            dup_err_q <= 1'b0;
            res_a_q   <= '0;
            res_b_q   <= '0;
            turn_q    <= '0;
            settle_q  <= '0;
            tick_q    <= '0;
            win_q     <= 1'b0;
            lose_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values of the others, independent of statement order.
            state_q   <= state_d;
            guess_q   <= guess_d;
            idx_q     <= idx_d;
            dup_err_q <= dup_err_d;
            res_a_q   <= res_a_d;
            res_b_q   <= res_b_d;
            turn_q    <= turn_d;
            settle_q  <= settle_d;
            tick_q    <= tick_d;
            win_q     <= win_d;
            lose_q    <= lose_d;
        end
    end

    // Next-state and datapath update for the turn sequence
    always_comb begin
        // NOTE: every signal gets a hold/idle default up front so no path
        // through the case leaves one unassigned and infers a latch.
        state_d   = state_q;
        guess_d   = guess_q;
        idx_d     = idx_q;
        dup_err_d = 1'b0;
        res_a_d   = res_a_q;
        res_b_d   = res_b_q;
        turn_d    = turn_q;
        settle_d  = settle_q;
        tick_d    = tick_q;
        win_d     = win_q;
        lose_d    = lose_q;
        digit_ok  = bus.digit_valid && (bus.digit_in <= 4'd9);
        is_dup    = 1'b0;

`ifndef ALLOW_DUP_DIGITS_EN
        // Only digits already entered (positions below the cursor) count
        for (int j = 0; j < DIGITS; j++) begin
            if (j < int'(idx_q) && guess_q[4*j +: 4] == bus.digit_in) begin
                is_dup = 1'b1;
            end
        end
`endif

        case (state_q)
            S_IDLE, S_WIN, S_LOSE: begin
                if (bus.start_pulse) begin
                    state_d = S_ENTRY;
                    guess_d = '1;
                    idx_d   = '0;
                    turn_d  = '0;
                    win_d   = 1'b0;
                    lose_d  = 1'b0;
                end
            end

            S_ENTRY: begin
                // Confirm wins over a same-cycle backspace even if the digit is rejected
                if (bus.confirm_pulse) begin
                    if (digit_ok) begin
                        if (is_dup) begin
                            dup_err_d = 1'b1;
                        end else begin
                            guess_d[4*int'(idx_q) +: 4] = bus.digit_in;
                            if (idx_q == IDX_W'(DIGITS - 1)) begin
                                idx_d    = '0;
                                settle_d = 4'(SETTLE_CYC);
                                state_d  = S_SETTLE;
                            end else begin
                                idx_d = idx_q + 1'b1;
                            end
                        end
                    end
                end else if (bus.back_pulse && idx_q != '0) begin
                    guess_d[4*(int'(idx_q) - 1) +: 4] = 4'hF;
                    idx_d = idx_q - 1'b1;
                end
            end

            S_SETTLE: begin
                if (settle_q == 4'd1) begin
                    res_a_d = bus.count_a_in;
                    res_b_d = bus.count_b_in;
                    if (turn_q != 3'(MAX_TURNS)) begin
                        turn_d = turn_q + 3'd1;
                    end
                    tick_d  = '0;
                    state_d = S_SHOW;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end

            S_SHOW: begin
                if (bus.confirm_pulse ||
                    (bus.blink_tick && tick_q == 4'(SHOW_TICKS - 1))) begin
                    if (res_a_q == 3'(DIGITS)) begin
                        state_d = S_WIN;
                        win_d   = 1'b1;
                    end else if (turn_q == 3'(MAX_TURNS)) begin
                        state_d = S_LOSE;
                        lose_d  = 1'b1;
                    end else begin
                        state_d = S_ENTRY;
                        guess_d = '1;
                        idx_d   = '0;
                    end
                end else if (bus.blink_tick) begin
                    tick_d = tick_q + 4'd1;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // Outputs come straight from registers or a decode of the state register
    assign bus.guess_flat  = guess_q;
    assign bus.guess_idx   = idx_q;
    assign bus.dup_err     = dup_err_q;
    assign bus.result_a    = res_a_q;
    assign bus.result_b    = res_b_q;
    assign bus.result_show = (state_q == S_SHOW);
    assign bus.turn_count  = turn_q;
    assign bus.in_entry    = (state_q == S_ENTRY);
    assign bus.win         = win_q;
    assign bus.lose        = lose_q;

endmodule

// File: tb/tb_guess_round_ctrl.sv
// Directed bench for guess_round_ctrl with DIGITS=4, MAX_TURNS=5,
// SETTLE_CYC=2, SHOW_TICKS=4. Expectations are hand-computed constants;
// duplicate-entry expectations follow ALLOW_DUP_DIGITS_EN.
module tb_guess_round_ctrl;
    logic CLK;
    logic RESET;
    int   compared   = 0;
    int   mismatched = 0;

    guess_round_if #(.DIGITS(4)) bus ();

    guess_round_ctrl #(
        .DIGITS(4), .MAX_TURNS(5), .SETTLE_CYC(2), .SHOW_TICKS(4)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1 time unit after it
    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic confirm(input logic [3:0] d);
        bus.digit_in      = d;
        bus.digit_valid   = 1'b1;
        bus.confirm_pulse = 1'b1;
        cycle();
        bus.confirm_pulse = 1'b0;
    endtask

    task automatic back();
        bus.back_pulse = 1'b1;
        cycle();
        bus.back_pulse = 1'b0;
    endtask

    task automatic start();
        bus.start_pulse = 1'b1;
        cycle();
        bus.start_pulse = 1'b0;
    endtask

    task automatic blink();
        bus.blink_tick = 1'b1;
        cycle();
        bus.blink_tick = 1'b0;
    endtask

    initial begin
        RESET             = 1'b1;
        bus.start_pulse   = 1'b0;
        bus.confirm_pulse = 1'b0;
        bus.back_pulse    = 1'b0;
        bus.digit_valid   = 1'b0;
        bus.digit_in      = 4'h0;
        bus.blink_tick    = 1'b0;
        bus.count_a_in    = 3'd4;
        bus.count_b_in    = 3'd0;

        // Reset state
        cycle();
        cycle();
        RESET = 1'b0;
        check("rst_guess", bus.guess_flat, 16'hFFFF);
        check("rst_idx", 16'(bus.guess_idx), 16'd0);
        check("rst_entry", 16'(bus.in_entry), 16'd0);
        check("rst_show", 16'(bus.result_show), 16'd0);
        check("rst_turn", 16'(bus.turn_count), 16'd0);
        check("rst_ab", {10'd0, bus.result_a, bus.result_b}, 16'd0);
        check("rst_flags", {13'd0, bus.win, bus.lose, bus.dup_err}, 16'd0);

        // Keys in IDLE are ignored
        confirm(4'd3);
        back();
        check("idle_guess", bus.guess_flat, 16'hFFFF);
        check("idle_entry", 16'(bus.in_entry), 16'd0);

        // Winning turn: 1,2,3,4 with scorer A=4 B=0
        start();
        check("start_entry", 16'(bus.in_entry), 16'd1);
        confirm(4'd1);
        confirm(4'd2);
        confirm(4'd3);
        check("win_guess3", bus.guess_flat, 16'hF321);
        check("win_idx3", 16'(bus.guess_idx), 16'd3);
        confirm(4'd4);
        check("settle_entry", 16'(bus.in_entry), 16'd0);
        check("settle_guess", bus.guess_flat, 16'h4321);
        check("settle_idx", 16'(bus.guess_idx), 16'd0);
        check("lat_show1", 16'(bus.result_show), 16'd0);
        confirm(4'd7);  // ignored while settling
        check("lat_show2", 16'(bus.result_show), 16'd0);
        check("settle_keys", bus.guess_flat, 16'h4321);
        cycle();
        check("lat_show3", 16'(bus.result_show), 16'd1);
        check("win_ra", 16'(bus.result_a), 16'd4);
        check("win_rb", 16'(bus.result_b), 16'd0);
        check("win_turn", 16'(bus.turn_count), 16'd1);
        blink();
        blink();
        blink();
        check("show_3ticks", 16'(bus.result_show), 16'd1);
        blink();
        check("show_4ticks", 16'(bus.result_show), 16'd0);
        check("win_flag", 16'(bus.win), 16'd1);
        check("win_nolose", 16'(bus.lose), 16'd0);
        confirm(4'd5);
        check("win_hold", bus.guess_flat, 16'h4321);

        // New game from WIN
        start();
        check("ng_entry", 16'(bus.in_entry), 16'd1);
        check("ng_win", 16'(bus.win), 16'd0);
        check("ng_turn", 16'(bus.turn_count), 16'd0);
        check("ng_guess", bus.guess_flat, 16'hFFFF);

        // Duplicate digit
        confirm(4'd5);
        check("dup_first", bus.guess_flat, 16'hFFF5);
        confirm(4'd5);
`ifdef ALLOW_DUP_DIGITS_EN
        check("dup_err", 16'(bus.dup_err), 16'd0);
        check("dup_guess", bus.guess_flat, 16'hFF55);
        check("dup_idx", 16'(bus.guess_idx), 16'd2);
        back();
`else
        check("dup_err", 16'(bus.dup_err), 16'd1);
        check("dup_guess", bus.guess_flat, 16'hFFF5);
        check("dup_idx", 16'(bus.guess_idx), 16'd1);
`endif
        back();
        check("dup_err_clr", 16'(bus.dup_err), 16'd0);
        check("back_to0", bus.guess_flat, 16'hFFFF);
        back();
        check("back_at0_g", bus.guess_flat, 16'hFFFF);
        check("back_at0_i", 16'(bus.guess_idx), 16'd0);

        // Backspace editing and simultaneous keys
        confirm(4'd7);
        confirm(4'd8);
        back();
        confirm(4'd9);
        check("edit_guess", bus.guess_flat, 16'hFF97);
        check("edit_idx", 16'(bus.guess_idx), 16'd2);
        bus.back_pulse = 1'b1;
        confirm(4'd3);
        bus.back_pulse = 1'b0;
        check("simul_guess", bus.guess_flat, 16'hF397);
        check("simul_idx", 16'(bus.guess_idx), 16'd3);

        // Invalid digits are ignored
        confirm(4'hC);
        check("bad_digit", bus.guess_flat, 16'hF397);
        bus.digit_in      = 4'd5;
        bus.digit_valid   = 1'b0;
        bus.confirm_pulse = 1'b1;
        cycle();
        bus.confirm_pulse = 1'b0;
        check("no_valid", bus.guess_flat, 16'hF397);
        check("no_valid_idx", 16'(bus.guess_idx), 16'd3);

        // Turn 1 with A=1 B=2, then early dismiss
        bus.count_a_in = 3'd1;
        bus.count_b_in = 3'd2;
        confirm(4'd6);
        check("t1_guess", bus.guess_flat, 16'h6397);
        cycle();
        cycle();
        check("t1_show", 16'(bus.result_show), 16'd1);
        check("t1_ab", {10'd0, bus.result_a, bus.result_b}, 16'o12);
        check("t1_turn", 16'(bus.turn_count), 16'd1);
        blink();
        confirm(4'd0);
        check("dismiss_entry", 16'(bus.in_entry), 16'd1);
        check("dismiss_show", 16'(bus.result_show), 16'd0);
        check("dismiss_guess", bus.guess_flat, 16'hFFFF);

        // Turns 2..5 losing
        for (int t = 2; t <= 5; t++) begin
            confirm(4'd1);
            confirm(4'd2);
            confirm(4'd3);
            confirm(4'd4);
            cycle();
            cycle();
            check($sformatf("turn%0d_cnt", t), 16'(bus.turn_count), 16'(t));
            blink();
            blink();
            blink();
            blink();
            if (t < 5) check($sformatf("turn%0d_entry", t), 16'(bus.in_entry), 16'd1);
        end
        check("lose_flag", 16'(bus.lose), 16'd1);
        check("lose_nowin", 16'(bus.win), 16'd0);
        check("lose_entry", 16'(bus.in_entry), 16'd0);
        check("lose_hold", bus.guess_flat, 16'h4321);

        // New game from LOSE
        start();
        check("nl_entry", 16'(bus.in_entry), 16'd1);
        check("nl_turn", 16'(bus.turn_count), 16'd0);
        check("nl_lose", 16'(bus.lose), 16'd0);

        // Reset mid-SETTLE
        confirm(4'd1);
        confirm(4'd2);
        confirm(4'd3);
        confirm(4'd4);
        RESET = 1'b1;
        cycle();
        RESET = 1'b0;
        check("rs_settle_g", bus.guess_flat, 16'hFFFF);
        check("rs_settle_a", 16'(bus.result_a), 16'd0);
        check("rs_settle_e", 16'(bus.in_entry), 16'd0);
        cycle();
        check("rs_settle_s", 16'(bus.result_show), 16'd0);

        // Reset mid-SHOW
        start();
        confirm(4'd1);
        confirm(4'd2);
        confirm(4'd3);
        confirm(4'd4);
        cycle();
        cycle();
        check("pre_rs_show", 16'(bus.result_show), 16'd1);
        RESET = 1'b1;
        cycle();
        RESET = 1'b0;
        check("rs_show_s", 16'(bus.result_show), 16'd0);
        check("rs_show_t", 16'(bus.turn_count), 16'd0);
        check("rs_show_ab", {10'd0, bus.result_a, bus.result_b}, 16'd0);
        check("rs_show_g", bus.guess_flat, 16'hFFFF);

        // Keys in IDLE after reset are ignored
        confirm(4'd8);
        check("post_rs_idle", 16'(bus.in_entry), 16'd0);
        check("post_rs_g", bus.guess_flat, 16'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
